// File: rtl/dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// dcache_port_arbiter
//
// Purpose
//    Shares the single-port DCache SRAM between the core load/store path and
//    a DMA/debug loader. The core has fixed priority, but a starvation guard
//    lets a waiting DMA through after STARVE_MAX cycles. A DMA burst may hold
//    ownership with i_dma_lock for at most LOCK_MAX back-to-back grants, after
//    which the core gets the next slot. Read data (one-cycle SRAM latency) is
//    routed back to whichever side issued the read.
//
// Ports
//    i_clk, i_rst               clock, synchronous active-high reset
//    i_core_*                   core request: req, we, addr, wmask, wdata
//    o_core_gnt/rvalid/rdata    core grant and read return
//    i_dma_*                    DMA request: req, we, addr, wmask, wdata, lock
//    o_dma_gnt/rvalid/rdata     DMA grant and read return
//    o_sram_*                   muxed SRAM command: cen, wren, addr, wmask, wdata
//    i_sram_rdata               SRAM read data, one cycle after a read command
//    o_core_stall_cnt           (DCARB_PERF_EN only) saturating count of cycles
//                               the core requested without being granted
//
// Configuration
//    DCARB_PERF_EN  adds the core stall counter and its output port.
// ---------------------------------------------------------------------------
module dcache_port_arbiter #(
   parameter int CACHE_WIDTHE  = 5,
   parameter int CACHE_DEEPTHE = 12,
   parameter int STARVE_MAX    = 4,
   parameter int LOCK_MAX      = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,

   input  logic                         i_core_req,
   input  logic                         i_core_we,
   input  logic [CACHE_DEEPTHE-1:0]     i_core_addr,
   input  logic [(2**CACHE_WIDTHE)-1:0] i_core_wmask,
   input  logic [(2**CACHE_WIDTHE)-1:0] i_core_wdata,
   output logic                         o_core_gnt,
   output logic                         o_core_rvalid,
   output logic [(2**CACHE_WIDTHE)-1:0] o_core_rdata,

   input  logic                         i_dma_req,
   input  logic                         i_dma_we,
   input  logic [CACHE_DEEPTHE-1:0]     i_dma_addr,
   input  logic [(2**CACHE_WIDTHE)-1:0] i_dma_wmask,
   input  logic [(2**CACHE_WIDTHE)-1:0] i_dma_wdata,
   input  logic                         i_dma_lock,
   output logic                         o_dma_gnt,
   output logic                         o_dma_rvalid,
   output logic [(2**CACHE_WIDTHE)-1:0] o_dma_rdata,

   output logic                         o_sram_cen,
   output logic                         o_sram_wren,
   output logic [CACHE_DEEPTHE-1:0]     o_sram_addr,
   output logic [(2**CACHE_WIDTHE)-1:0] o_sram_wmask,
   output logic [(2**CACHE_WIDTHE)-1:0] o_sram_wdata,
   input  logic [(2**CACHE_WIDTHE)-1:0] i_sram_rdata
`ifdef DCARB_PERF_EN
   ,
   output logic [15:0]                  o_core_stall_cnt
`endif
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [7:0] LOCK_LIM   = 8'(LOCK_MAX);

   typedef enum logic [0:0] {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_stateNext;
   logic [3:0] r_starveCnt;
   logic [3:0] w_starveNext;
   logic [7:0] r_lockCnt;
   logic [7:0] w_lockNext;
   logic [7:0] w_lockInc;
   logic       r_forceCore;
   logic       w_forceNext;
   logic       r_coreRdOwner;
   logic       r_dmaRdOwner;
   logic       w_coreGnt;
   logic       w_dmaGnt;

   // Grant decision. In LOCK the DMA owns the port; the core only gets a slot
   // there when the DMA is not asking. In ARB the core wins unless the DMA
   // has starved long enough, except right after a forced lock release where
   // the core is guaranteed the slot whatever the starvation count says.
   always_comb begin
      w_coreGnt = 1'b0;
      w_dmaGnt  = 1'b0;
      if (!i_rst) begin
         if (r_state == ST_LOCK) begin
            if (i_dma_req) begin
               w_dmaGnt = 1'b1;
            end else if (i_core_req) begin
               w_coreGnt = 1'b1;
            end
         end else begin
            if (r_forceCore && i_core_req) begin
               w_coreGnt = 1'b1;
            end else if (i_dma_req && (r_starveCnt == STARVE_LIM)) begin
               w_dmaGnt = 1'b1;
            end else if (i_core_req) begin
               w_coreGnt = 1'b1;
            end else if (i_dma_req) begin
               w_dmaGnt = 1'b1;
            end
         end
      end
   end

   // Lock FSM next state. lock_cnt counts locked grants in the current burst
   // (the ARB grant that opens the burst is beat 1); the burst is cut when
   // the beat being granted brings the count up to LOCK_LIM.
   always_comb begin
      w_stateNext = r_state;
      w_lockNext  = r_lockCnt;
      w_forceNext = 1'b0;
      w_lockInc   = 8'(r_lockCnt + 8'd1);
      case (r_state)
         ST_ARB: begin
            if (w_dmaGnt && i_dma_lock) begin
               if (LOCK_LIM == 8'd1) begin
                  w_forceNext = 1'b1;
                  w_lockNext  = 8'd0;
               end else begin
                  w_stateNext = ST_LOCK;
                  w_lockNext  = 8'd1;
               end
            end
         end
         ST_LOCK: begin
            if (!i_dma_req) begin
               w_stateNext = ST_ARB;
               w_lockNext  = 8'd0;
            end else if (w_dmaGnt && !i_dma_lock) begin
               w_stateNext = ST_ARB;
               w_lockNext  = 8'd0;
            end else if (w_dmaGnt && (w_lockInc == LOCK_LIM)) begin
               w_stateNext = ST_ARB;
               w_lockNext  = 8'd0;
               w_forceNext = 1'b1;
            end else if (w_dmaGnt) begin
               w_lockNext  = w_lockInc;
            end
         end
         default: begin
            w_stateNext = ST_ARB;
            w_lockNext  = 8'd0;
         end
      endcase
   end

   // Starvation counter: counts cycles the DMA waits, saturating at the limit,
   // and restarts whenever the DMA is served or withdraws its request.
   always_comb begin
      w_starveNext = r_starveCnt;
      if (!i_dma_req || w_dmaGnt) begin
         w_starveNext = 4'd0;
      end else if (r_starveCnt != STARVE_LIM) begin
         w_starveNext = 4'(r_starveCnt + 4'd1);
      end
   end

   // State registers plus the read-owner flags that steer the returning
   // SRAM data one cycle after a read grant.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_ARB;
         r_starveCnt   <= 4'd0;
         r_lockCnt     <= 8'd0;
         r_forceCore   <= 1'b0;
         r_coreRdOwner <= 1'b0;
         r_dmaRdOwner  <= 1'b0;
      end else begin
         r_state       <= w_stateNext;
         r_starveCnt   <= w_starveNext;
         r_lockCnt     <= w_lockNext;
         r_forceCore   <= w_forceNext;
         r_coreRdOwner <= w_coreGnt & ~i_core_we;
         r_dmaRdOwner  <= w_dmaGnt & ~i_dma_we;
      end
   end

   // SRAM command mux: the winner's fields, all zero when nobody is granted.
   always_comb begin
      o_sram_wren  = 1'b0;
      o_sram_addr  = '0;
      o_sram_wmask = '0;
      o_sram_wdata = '0;
      if (w_coreGnt) begin
         o_sram_wren  = i_core_we;
         o_sram_addr  = i_core_addr;
         o_sram_wmask = i_core_wmask;
         o_sram_wdata = i_core_wdata;
      end else if (w_dmaGnt) begin
         o_sram_wren  = i_dma_we;
         o_sram_addr  = i_dma_addr;
         o_sram_wmask = i_dma_wmask;
         o_sram_wdata = i_dma_wdata;
      end
   end

   // Read return; rvalid is masked during reset so every output reads zero.
   assign o_core_gnt    = w_coreGnt;
   assign o_dma_gnt     = w_dmaGnt;
   assign o_sram_cen    = w_coreGnt | w_dmaGnt;
   assign o_core_rvalid = r_coreRdOwner & ~i_rst;
   assign o_dma_rvalid  = r_dmaRdOwner & ~i_rst;
   assign o_core_rdata  = o_core_rvalid ? i_sram_rdata : '0;
   assign o_dma_rdata   = o_dma_rvalid ? i_sram_rdata : '0;

`ifdef DCARB_PERF_EN
   logic [15:0] r_stallCnt;

   // Saturating count of cycles the core asked for the port and lost.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stallCnt <= 16'd0;
      end else if (i_core_req && !w_coreGnt && (r_stallCnt != 16'hFFFF)) begin
         r_stallCnt <= r_stallCnt + 16'd1;
      end
   end

   assign o_core_stall_cnt = i_rst ? 16'd0 : r_stallCnt;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dcache_port_arbiter
//
// Directed bench for dcache_port_arbiter with a small behavioural SRAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_dcache_port_arbiter;

   logic        clock;
   logic        reset;

   logic        coreReq, coreWe;
   logic [11:0] coreAddr;
   logic [31:0] coreWmask, coreWdata;
   logic        coreGnt, coreRvalid;
   logic [31:0] coreRdata;

   logic        dmaReq, dmaWe, dmaLock;
   logic [11:0] dmaAddr;
   logic [31:0] dmaWmask, dmaWdata;
   logic        dmaGnt, dmaRvalid;
   logic [31:0] dmaRdata;

   logic        sramCen, sramWren;
   logic [11:0] sramAddr;
   logic [31:0] sramWmask, sramWdata, sramRdata;

   int checks   = 0;
   int failures = 0;

`ifdef DCARB_PERF_EN
   logic [15:0] coreStallCnt;
`endif

   dcache_port_arbiter #(
      .CACHE_WIDTHE (5),
      .CACHE_DEEPTHE(12),
      .STARVE_MAX   (4),
      .LOCK_MAX     (8)
   ) dut (
      .i_clk        (clock),
      .i_rst        (reset),
      .i_core_req   (coreReq),
      .i_core_we    (coreWe),
      .i_core_addr  (coreAddr),
      .i_core_wmask (coreWmask),
      .i_core_wdata (coreWdata),
      .o_core_gnt   (coreGnt),
      .o_core_rvalid(coreRvalid),
      .o_core_rdata (coreRdata),
      .i_dma_req    (dmaReq),
      .i_dma_we     (dmaWe),
      .i_dma_addr   (dmaAddr),
      .i_dma_wmask  (dmaWmask),
      .i_dma_wdata  (dmaWdata),
      .i_dma_lock   (dmaLock),
      .o_dma_gnt    (dmaGnt),
      .o_dma_rvalid (dmaRvalid),
      .o_dma_rdata  (dmaRdata),
      .o_sram_cen   (sramCen),
      .o_sram_wren  (sramWren),
      .o_sram_addr  (sramAddr),
      .o_sram_wmask (sramWmask),
      .o_sram_wdata (sramWdata),
      .i_sram_rdata (sramRdata)
`ifdef DCARB_PERF_EN
      ,
      .o_core_stall_cnt(coreStallCnt)
`endif
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural single-port SRAM: masked writes, one-cycle read latency.
   // Two known words are loaded whenever reset is held.
   logic [31:0] mem [0:4095];
   always @(posedge clock) begin
      if (reset) begin
         mem[12'h010] <= 32'hDEADBEEF;
         mem[12'h020] <= 32'hAAAAAAAA;
      end else if (sramCen) begin
         if (sramWren) begin
            mem[sramAddr] <= (mem[sramAddr] & ~sramWmask) | (sramWdata & sramWmask);
         end else begin
            sramRdata <= mem[sramAddr];
         end
      end
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives both requester interfaces in one call.
   task automatic applyStimulus(
      input logic cReq, input logic cWe, input logic [11:0] cAddr,
      input logic [31:0] cMask, input logic [31:0] cData,
      input logic dReq, input logic dWe, input logic [11:0] dAddr,
      input logic [31:0] dMask, input logic [31:0] dData, input logic dLk);
      coreReq   = cReq;  coreWe   = cWe;  coreAddr  = cAddr;
      coreWmask = cMask; coreWdata = cData;
      dmaReq    = dReq;  dmaWe    = dWe;  dmaAddr   = dAddr;
      dmaWmask  = dMask; dmaWdata = dData; dmaLock  = dLk;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0] expGnt;

      // ---- Reset: nothing granted, all SRAM outputs zero -------------------
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 12'h010, 32'h0, 32'h0,
                    1'b1, 1'b0, 12'h020, 32'h0, 32'h0, 1'b0);
      @(negedge clock);
      checkOutput("rst_gnts", {30'd0, coreGnt, dmaGnt}, 32'd0);
      checkOutput("rst_cen", {31'd0, sramCen}, 32'd0);
      checkOutput("rst_addr", {20'd0, sramAddr}, 32'd0);
      checkOutput("rst_rvalid", {30'd0, coreRvalid, dmaRvalid}, 32'd0);
      nextCycle();
      nextCycle();
      reset = 1'b0;

      // ---- Idle: fields present but no request -> SRAM bus is zero ---------
      applyStimulus(1'b0, 1'b1, 12'h123, 32'hFFFFFFFF, 32'h55AA55AA,
                    1'b0, 1'b1, 12'h456, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0);
      @(negedge clock);
      checkOutput("idle_cen", {31'd0, sramCen}, 32'd0);
      checkOutput("idle_addr", {20'd0, sramAddr}, 32'd0);
      checkOutput("idle_wdata", sramWdata, 32'd0);
      checkOutput("idle_wren", {31'd0, sramWren}, 32'd0);

      // ---- Core read of 0x010 ----------------------------------------------
      nextCycle();
      applyStimulus(1'b1, 1'b0, 12'h010, 32'h0, 32'h0,
                    1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clock);
      checkOutput("t1_core_gnt", {31'd0, coreGnt}, 32'd1);
      checkOutput("t1_cen", {31'd0, sramCen}, 32'd1);
      checkOutput("t1_wren", {31'd0, sramWren}, 32'd0);
      checkOutput("t1_addr", {20'd0, sramAddr}, 32'h010);
      nextCycle();
      applyIdle();
      @(negedge clock);
      checkOutput("t1_core_rvalid", {31'd0, coreRvalid}, 32'd1);
      checkOutput("t1_core_rdata", coreRdata, 32'hDEADBEEF);
      checkOutput("t1_dma_rvalid", {31'd0, dmaRvalid}, 32'd0);
      nextCycle();
      @(negedge clock);
      checkOutput("t1_rvalid_drop", {31'd0, coreRvalid}, 32'd0);
      checkOutput("t1_rdata_zero", coreRdata, 32'd0);

      // ---- Starvation guard: DMA wins on the 5th cycle ---------------------
      nextCycle();
      applyStimulus(1'b1, 1'b1, 12'h100, 32'h0, 32'h0,
                    1'b1, 1'b1, 12'h200, 32'h0, 32'h0, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         expGnt = (c == 5) ? 2'b01 : 2'b10;
         checkOutput($sformatf("t2_gnt_c%0d", c), {30'd0, coreGnt, dmaGnt},
                     {30'd0, expGnt});
         nextCycle();
      end
      applyIdle();
      nextCycle();

      // ---- Locked burst: 8 DMA beats, forced core slot, DMA re-locks -------
      applyStimulus(1'b1, 1'b1, 12'h100, 32'h0, 32'h0,
                    1'b1, 1'b1, 12'h200, 32'h0, 32'h0, 1'b1);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clock);
         expGnt = ((c >= 5 && c <= 12) || c >= 17) ? 2'b01 : 2'b10;
         checkOutput($sformatf("t3_gnt_c%0d", c), {30'd0, coreGnt, dmaGnt},
                     {30'd0, expGnt});
         nextCycle();
      end
      applyIdle();
      nextCycle();
      nextCycle();

      // ---- DMA masked write then core read of the same word ----------------
      applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 12'h020, 32'h0000FFFF, 32'h12345678, 1'b0);
      @(negedge clock);
      checkOutput("t4_dma_gnt", {31'd0, dmaGnt}, 32'd1);
      checkOutput("t4_wren", {31'd0, sramWren}, 32'd1);
      checkOutput("t4_wmask", sramWmask, 32'h0000FFFF);
      checkOutput("t4_wdata", sramWdata, 32'h12345678);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 12'h020, 32'h0, 32'h0,
                    1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clock);
      checkOutput("t4_core_gnt", {31'd0, coreGnt}, 32'd1);
      checkOutput("t4_write_no_rvalid", {31'd0, dmaRvalid}, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 12'h010, 32'h0, 32'h0, 1'b0);
      @(negedge clock);
      checkOutput("t4_core_rvalid", {31'd0, coreRvalid}, 32'd1);
      checkOutput("t4_core_rdata", coreRdata, 32'hAAAA5678);
      checkOutput("t4_dma_rd_gnt", {31'd0, dmaGnt}, 32'd1);
      nextCycle();
      applyIdle();
      @(negedge clock);
      checkOutput("t4_dma_rvalid", {31'd0, dmaRvalid}, 32'd1);
      checkOutput("t4_dma_rdata", dmaRdata, 32'hDEADBEEF);
      checkOutput("t4_core_rvalid_off", {31'd0, coreRvalid}, 32'd0);
      checkOutput("t4_core_rdata_zero", coreRdata, 32'd0);

      // ---- Reset interacting with reads and the starvation count -----------
      nextCycle();
      applyStimulus(1'b1, 1'b0, 12'h010, 32'h0, 32'h0,
                    1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clock);
      checkOutput("t5_pre_gnt", {31'd0, coreGnt}, 32'd1);
      nextCycle();
      reset = 1'b1;
      applyIdle();
      @(negedge clock);
      checkOutput("t5_rvalid_in_rst", {31'd0, coreRvalid}, 32'd0);
      checkOutput("t5_rdata_in_rst", coreRdata, 32'd0);
      nextCycle();
      reset = 1'b0;
      @(negedge clock);
      checkOutput("t5_rvalid_after", {31'd0, coreRvalid}, 32'd0);

      nextCycle();
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 12'h010, 32'h0, 32'h0,
                    1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clock);
      checkOutput("t5_gnt_in_rst", {31'd0, coreGnt}, 32'd0);
      nextCycle();
      reset = 1'b0;
      applyIdle();
      @(negedge clock);
      checkOutput("t5_no_rvalid", {31'd0, coreRvalid}, 32'd0);

      // Build up starvation, reset, then confirm the count restarted at 0.
      nextCycle();
      applyStimulus(1'b1, 1'b1, 12'h100, 32'h0, 32'h0,
                    1'b1, 1'b1, 12'h200, 32'h0, 32'h0, 1'b0);
      nextCycle();
      nextCycle();
      nextCycle();
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         expGnt = (c == 5) ? 2'b01 : 2'b10;
         checkOutput($sformatf("t5_starve_c%0d", c), {30'd0, coreGnt, dmaGnt},
                     {30'd0, expGnt});
         nextCycle();
      end
      applyIdle();
      nextCycle();

`ifdef DCARB_PERF_EN
      // ---- Stall counter: core held off 3 cycles by a locked DMA -----------
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 12'h200, 32'h0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t6_lock_gnt", {31'd0, dmaGnt}, 32'd1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 12'h100, 32'h0, 32'h0,
                    1'b1, 1'b1, 12'h200, 32'h0, 32'h0, 1'b1);
      nextCycle();
      nextCycle();
      nextCycle();
      applyStimulus(1'b1, 1'b1, 12'h100, 32'h0, 32'h0,
                    1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clock);
      checkOutput("t6_core_gnt", {31'd0, coreGnt}, 32'd1);
      checkOutput("t6_stall_cnt", {16'd0, coreStallCnt}, 32'd3);
      nextCycle();
      applyIdle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
